// File: rtl/mod_counter_stage.sv
// -----------------------------------------------------------------------------
// mod_counter_stage
//
// Modulo-MODULUS counter stage for a 24-hour clock datapath running on a
// 1 Hz clock. Stages cascade through carry_out -> en: seconds (mod 60) feeds
// minutes (mod 60), which feeds hours (mod 24).
//
// Parameters
//   MODULUS  number of states, count runs 0..MODULUS-1 (2..2**WIDTH)
//   WIDTH    count width in bits, 2**WIDTH >= MODULUS
//
// Ports
//   clk_1Hz     in   counting clock, rising edge
//   rst         in   asynchronous active-high reset, clears all state
//   en          in   count enable (previous stage carry_out, or tied high)
//   down        in   direction: 0 up, 1 down
//   load        in   synchronous load request (time set)
//   load_value  in   value applied on load, rejected if >= MODULUS
//   count       out  registered count
//   carry_out   out  combinational: en & ~load & count at terminal value
//   tick        out  registered one-cycle pulse in the cycle after a wrap
//   load_err    out  registered one-cycle pulse after a rejected load
//   bcd_tens    out  tens digit of count (0 when BCD disabled)
//   bcd_ones    out  ones digit of count (0 when BCD disabled)
//
// Configuration
//   MOD_COUNTER_BCD_EN  when defined, bcd_tens/bcd_ones are registered digits
//                       maintained incrementally alongside count (no divider).
//                       Requires MODULUS <= 100. When undefined the digits are
//                       constant 0 and no BCD logic is built.
//
// Update priority on each edge: rst (async) > load > en > hold.
// -----------------------------------------------------------------------------
module mod_counter_stage #(
  parameter int MODULUS = 60,
  parameter int WIDTH   = 6
) (
  input  logic             clk_1Hz,
  input  logic             rst,
  input  logic             en,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             carry_out,
  output logic             tick,
  output logic             load_err,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones
);

  // Largest legal count, and the modulus widened by one bit so that
  // MODULUS == 2**WIDTH is still representable in the range compare.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             at_term;
  logic             load_ok;

  // Terminal value depends on the direction currently requested, so the
  // carry tracks a direction change in the same cycle.
  assign at_term = down ? (count_q == '0) : (count_q == MAX_VAL);
  assign load_ok = ({1'b0, load_value} < MOD_EXT);

  // Never registered: cascaded stages must all wrap on the same edge.
  assign carry_out = en & ~load & at_term;

  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      // en is ignored on a load cycle, whether or not the load is accepted.
      if (load_ok) begin
        count_d = load_value;
      end else begin
        err_d = 1'b1;
      end
    end else if (en) begin
      if (down) begin
        if (count_q == '0) begin
          count_d = MAX_VAL;
          tick_d  = 1'b1;
        end else begin
          count_d = count_q - ONE;
        end
      end else begin
        if (count_q == MAX_VAL) begin
          count_d = '0;
          tick_d  = 1'b1;
        end else begin
          count_d = count_q + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  assign count    = count_q;
  assign tick     = tick_q;
  assign load_err = err_q;

`ifdef MOD_COUNTER_BCD_EN

  localparam logic [3:0] MAX_TENS = 4'((MODULUS - 1) / 10);
  localparam logic [3:0] MAX_ONES = 4'((MODULUS - 1) % 10);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [7:0] load_bcd;

  // Binary to BCD for the load path: find the largest multiple of ten not
  // exceeding the value by comparing against constants, then subtract it.
  function automatic logic [7:0] to_bcd(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    logic [3:0]  t;
    r = 32'(v);
    t = 4'd0;
    for (int k = 9; k >= 1; k--) begin
      if ((t == 4'd0) && (r >= 32'(k * 10))) begin
        t = 4'(k);
        r = r - 32'(k * 10);
      end
    end
    return {t, 4'(r)};
  endfunction

  assign load_bcd = to_bcd(load_value);

  // Digits follow exactly the same decision tree as count_d, so they stay
  // equal to count/10 and count%10 on every edge.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (load) begin
      if (load_ok) begin
        tens_d = load_bcd[7:4];
        ones_d = load_bcd[3:0];
      end
    end else if (en) begin
      if (down) begin
        if (count_q == '0) begin
          tens_d = MAX_TENS;
          ones_d = MAX_ONES;
        end else if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end else begin
        if (count_q == MAX_VAL) begin
          tens_d = 4'd0;
          ones_d = 4'd0;
        end else if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign bcd_tens = tens_q;
  assign bcd_ones = ones_q;

`else

  assign bcd_tens = 4'd0;
  assign bcd_ones = 4'd0;

`endif

endmodule
